// File: rtl/video_timing.sv
// Raster timing generator: IDLE/RUN/STOP sequencer, h/v counters and a
// LOOKAHEAD+1 deep pipeline that aligns the sync/enable flags behind req.
module video_timing #(
    parameter int unsigned CW        = 11,
    parameter int unsigned HWIDTH    = 960,
    parameter int unsigned HSYNC0    = 1000,
    parameter int unsigned HSYNC1    = 1100,
    parameter int unsigned HMAX      = 1199,
    parameter int unsigned VHEIGHT   = 600,
    parameter int unsigned VSYNC0    = 613,
    parameter int unsigned VSYNC1    = 620,
    parameter int unsigned VMAX      = 624,
    parameter logic        HPOL      = 1'b1,
    parameter logic        VPOL      = 1'b1,
    parameter int unsigned LOOKAHEAD = 2
) (
    input  logic          pixclk,
    input  logic          reset_n,
    input  logic          enable,
    output logic          running,
    output logic          req,
    output logic [CW-1:0] xpixel,
    output logic [CW-1:0] ypixel,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start
);

    if (!(HWIDTH <= HSYNC0 && HSYNC0 < HSYNC1 && HSYNC1 <= HMAX)) begin : g_bad_h
        $fatal(1, "video_timing: illegal horizontal timing parameters");
    end
    if (!(VHEIGHT <= VSYNC0 && VSYNC0 < VSYNC1 && VSYNC1 <= VMAX)) begin : g_bad_v
        $fatal(1, "video_timing: illegal vertical timing parameters");
    end
    if (CW < 1 || CW > 31 || HMAX > (2 ** CW) - 1 || VMAX > (2 ** CW) - 1) begin : g_bad_cw
        $fatal(1, "video_timing: HMAX/VMAX do not fit in CW bits");
    end
    if (LOOKAHEAD > 7) begin : g_bad_la
        $fatal(1, "video_timing: LOOKAHEAD must be 0..7");
    end

    localparam logic [CW-1:0] HWIDTH_C  = CW'(HWIDTH);
    localparam logic [CW-1:0] HSYNC0_C  = CW'(HSYNC0);
    localparam logic [CW-1:0] HSYNC1_C  = CW'(HSYNC1);
    localparam logic [CW-1:0] HMAX_C    = CW'(HMAX);
    localparam logic [CW-1:0] VHEIGHT_C = CW'(VHEIGHT);
    localparam logic [CW-1:0] VSYNC0_C  = CW'(VSYNC0);
    localparam logic [CW-1:0] VSYNC1_C  = CW'(VSYNC1);
    localparam logic [CW-1:0] VMAX_C    = CW'(VMAX);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic ls;
        logic fs;
    } flags_t;

    state_e          state_q, state_d;
    logic [CW-1:0]   hcount_q, hcount_d;
    logic [CW-1:0]   vcount_q, vcount_d;
    logic            end_of_frame;
    flags_t          raw;
    flags_t          pipe_q [0:LOOKAHEAD];

    assign end_of_frame = (hcount_q == HMAX_C) && (vcount_q == VMAX_C);

    always_ff @(posedge pixclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // STOP only retires to IDLE on the last pixel so a frame is never cut short.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = STOP;
            STOP: begin
                if (enable)            state_d = RUN;
                else if (end_of_frame) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (state_q != IDLE) begin
            if (hcount_q == HMAX_C) begin
                hcount_d = '0;
                vcount_d = (vcount_q == VMAX_C) ? '0 : vcount_q + CW'(1);
            end else begin
                hcount_d = hcount_q + CW'(1);
            end
        end
    end

    always_ff @(posedge pixclk or negedge reset_n) begin
        if (!reset_n) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    always_comb begin
        running = (state_q != IDLE);
        xpixel  = hcount_q;
        ypixel  = vcount_q;
        req     = running && (hcount_q < HWIDTH_C) && (vcount_q < VHEIGHT_C);
        raw.de  = req;
        raw.hs  = running && (hcount_q >= HSYNC0_C) && (hcount_q < HSYNC1_C);
        raw.vs  = running && (vcount_q >= VSYNC0_C) && (vcount_q < VSYNC1_C);
        raw.ls  = running && (hcount_q == '0);
        raw.fs  = raw.ls && (vcount_q == '0);
    end

    always_ff @(posedge pixclk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_q[0] <= '0;
        end else begin
            pipe_q[0] <= raw;
        end
    end

    for (genvar g = 1; g <= LOOKAHEAD; g++) begin : g_pipe
        always_ff @(posedge pixclk or negedge reset_n) begin
            if (!reset_n) begin
                pipe_q[g] <= '0;
            end else begin
                pipe_q[g] <= pipe_q[g-1];
            end
        end
    end

    assign de          = pipe_q[LOOKAHEAD].de;
    assign hsync       = pipe_q[LOOKAHEAD].hs ? HPOL : ~HPOL;
    assign vsync       = pipe_q[LOOKAHEAD].vs ? VPOL : ~VPOL;
    assign line_start  = pipe_q[LOOKAHEAD].ls;
    assign frame_start = pipe_q[LOOKAHEAD].fs;

endmodule
